// File: rtl/led_scan_driver.sv
// Two-digit seven-segment scan driver with blanking between digits, plus
// pulse stretchers for the FIZZ/BUZZ indicator LEDs. All inputs are
// double-flopped; every output comes straight from a flop.
module led_scan_driver #(
    parameter int SCAN_DIV       = 5000,
    parameter int ON_TICKS       = 4,
    parameter int BLANK_TICKS    = 1,
    parameter int STRETCH_TICKS  = 800,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic       CLK20MHz,
    input  logic       RST_N,
    input  logic [7:0] SEG0_IN,
    input  logic [7:0] SEG1_IN,
    input  logic       FIZZ_IN,
    input  logic       BUZZ_IN,
    output logic [7:0] SEG_OUT,
    output logic [1:0] DIG_SEL,
    output logic       FIZZ_LED,
    output logic       BUZZ_LED
);

    localparam int PW     = $clog2(SCAN_DIV);
    localparam int PH_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int SW     = $clog2(STRETCH_TICKS + 1);

    // XOR masks: applying them to an active-high value yields the pin level.
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    localparam logic [PW-1:0]  PRESC_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PHW-1:0] ON_LAST      = PHW'(ON_TICKS - 1);
    localparam logic [PHW-1:0] BLANK_LAST   = PHW'(BLANK_TICKS - 1);
    localparam logic [SW-1:0]  STRETCH_LOAD = SW'(STRETCH_TICKS);

    typedef enum logic [1:0] {
        ST_DIG0   = 2'd0,
        ST_BLANK0 = 2'd1,
        ST_DIG1   = 2'd2,
        ST_BLANK1 = 2'd3
    } scan_state_t;

    logic [7:0]     seg0_s1_q, seg0_s2_q;
    logic [7:0]     seg1_s1_q, seg1_s2_q;
    logic [1:0]     flag_s1_q, flag_s2_q, flag_s3_q;   // bit0 = fizz, bit1 = buzz
    logic [PW-1:0]  presc_q;
    logic           scan_tick;
    scan_state_t    state_q;
    logic [PHW-1:0] phase_q;
    logic [PHW-1:0] phase_last;
    logic [7:0]     seg_out_q;
    logic [1:0]     dig_sel_q;
    logic [1:0]     led_vec;

    // Two-flop synchronisers for all inputs; flags get a third flop for edge detect.
    always_ff @(posedge CLK20MHz or negedge RST_N) begin
        if (!RST_N) begin
            seg0_s1_q <= '0;
            seg0_s2_q <= '0;
            seg1_s1_q <= '0;
            seg1_s2_q <= '0;
            flag_s1_q <= '0;
            flag_s2_q <= '0;
            flag_s3_q <= '0;
        end else begin
            seg0_s1_q <= SEG0_IN;
            seg0_s2_q <= seg0_s1_q;
            seg1_s1_q <= SEG1_IN;
            seg1_s2_q <= seg1_s1_q;
            flag_s1_q <= {BUZZ_IN, FIZZ_IN};
            flag_s2_q <= flag_s1_q;
            flag_s3_q <= flag_s2_q;
        end
    end

    // Prescaler: free-running 0..SCAN_DIV-1, tick on the terminal count.
    always_ff @(posedge CLK20MHz or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign scan_tick  = (presc_q == PRESC_LAST);
    assign phase_last = (state_q == ST_DIG0 || state_q == ST_DIG1) ? ON_LAST : BLANK_LAST;

    // Scan FSM; segment pattern is latched on digit entry and held for the phase.
    always_ff @(posedge CLK20MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_BLANK1;
            phase_q   <= BLANK_LAST;
            seg_out_q <= SEG_OFF;
            dig_sel_q <= DIG_OFF;
        end else if (scan_tick) begin
            if (phase_q == phase_last) begin
                phase_q <= '0;
                case (state_q)
                    ST_DIG0: begin
                        state_q   <= ST_BLANK0;
                        seg_out_q <= SEG_OFF;
                        dig_sel_q <= DIG_OFF;
                    end
                    ST_BLANK0: begin
                        state_q   <= ST_DIG1;
                        seg_out_q <= seg1_s2_q ^ SEG_OFF;
                        dig_sel_q <= 2'b10 ^ DIG_OFF;
                    end
                    ST_DIG1: begin
                        state_q   <= ST_BLANK1;
                        seg_out_q <= SEG_OFF;
                        dig_sel_q <= DIG_OFF;
                    end
                    default: begin
                        state_q   <= ST_DIG0;
                        seg_out_q <= seg0_s2_q ^ SEG_OFF;
                        dig_sel_q <= 2'b01 ^ DIG_OFF;
                    end
                endcase
            end else begin
                phase_q <= phase_q + PHW'(1);
            end
        end
    end

    // One independent stretcher per flag: index 0 = fizz, 1 = buzz.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stretch
            logic [SW-1:0] cnt_q;
            logic          led_q;
            logic          rise;

            assign rise = flag_s2_q[gi] & ~flag_s3_q[gi];

            // Reload on rising edge (wins over tick), otherwise count down on ticks.
            always_ff @(posedge CLK20MHz or negedge RST_N) begin
                if (!RST_N) begin
                    cnt_q <= '0;
                    led_q <= 1'b0;
                end else if (rise) begin
                    cnt_q <= STRETCH_LOAD;
                    led_q <= 1'b1;
                end else if (scan_tick && cnt_q != '0) begin
                    cnt_q <= cnt_q - SW'(1);
                    led_q <= (cnt_q != SW'(1));
                end
            end

            assign led_vec[gi] = led_q;
        end
    endgenerate

    assign SEG_OUT  = seg_out_q;
    assign DIG_SEL  = dig_sel_q;
    assign FIZZ_LED = led_vec[0];
    assign BUZZ_LED = led_vec[1];

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: two instances (active-high and active-low
// polarities) share stimulus; expectations come from an arithmetic model
// of scan position and stretch expiry derived from rising-edge counts.
module tb_led_scan_driver;

    localparam int SD = 4;   // SCAN_DIV
    localparam int ON = 2;   // ON_TICKS
    localparam int BL = 1;   // BLANK_TICKS
    localparam int ST = 3;   // STRETCH_TICKS
    localparam int FT = 2 * (ON + BL);   // ticks per frame

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg0, seg1;
    logic       fizz, buzz;
    logic [7:0] seg_out, seg_out_al;
    logic [1:0] dig_sel, dig_sel_al;
    logic       fizz_led, buzz_led, fizz_led_al, buzz_led_al;

    int total = 0;
    int bad   = 0;
    int k     = 0;              // rising edges since reset release
    int f_off = 0;              // edge index at which fizz LED goes dark
    int b_off = 0;
    logic [17:0] hist [0:4095]; // {buzz, fizz, seg1, seg0} seen at edge k
    logic [7:0]  e_seg;
    logic [1:0]  e_dig;

    always #5 clk = ~clk;

    led_scan_driver #(
        .SCAN_DIV(SD), .ON_TICKS(ON), .BLANK_TICKS(BL), .STRETCH_TICKS(ST),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .CLK20MHz(clk), .RST_N(rst_n), .SEG0_IN(seg0), .SEG1_IN(seg1),
        .FIZZ_IN(fizz), .BUZZ_IN(buzz), .SEG_OUT(seg_out), .DIG_SEL(dig_sel),
        .FIZZ_LED(fizz_led), .BUZZ_LED(buzz_led)
    );

    led_scan_driver #(
        .SCAN_DIV(SD), .ON_TICKS(ON), .BLANK_TICKS(BL), .STRETCH_TICKS(ST),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_al (
        .CLK20MHz(clk), .RST_N(rst_n), .SEG0_IN(seg0), .SEG1_IN(seg1),
        .FIZZ_IN(fizz), .BUZZ_IN(buzz), .SEG_OUT(seg_out_al), .DIG_SEL(dig_sel_al),
        .FIZZ_LED(fizz_led_al), .BUZZ_LED(buzz_led_al)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h want %h", tag, k, obs, exp_v);
        end
    endtask

    // Input value the design has after two synchroniser stages at edge j.
    function automatic logic [17:0] s2_at(input int j);
        return (j - 2 >= 1) ? hist[j - 2] : 18'h0;
    endfunction

    function automatic logic [17:0] s3_at(input int j);
        return (j - 3 >= 1) ? hist[j - 3] : 18'h0;
    endfunction

    // Scan position from tick count: first tick enters DIG0, then frame repeats.
    task automatic model_scan(input int j, output logic [7:0] seg, output logic [1:0] dig);
        int t;
        int p;
        logic [17:0] v;
        t   = j / SD;
        seg = 8'h00;
        dig = 2'b00;
        if (t > 0) begin
            p = (t - 1) % FT;
            if (p < ON) begin
                v   = s2_at((t - p) * SD);
                seg = v[7:0];
                dig = 2'b01;
            end else if (p >= ON + BL && p < 2 * ON + BL) begin
                v   = s2_at((t - (p - ON - BL)) * SD);
                seg = v[15:8];
                dig = 2'b10;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"},    seg_out,              8'h00);
        chk({tag, "_dig"},    {6'b0, dig_sel},      8'h00);
        chk({tag, "_fizz"},   {7'b0, fizz_led},     8'h00);
        chk({tag, "_buzz"},   {7'b0, buzz_led},     8'h00);
        chk({tag, "_seg_al"}, seg_out_al,           8'hFF);
        chk({tag, "_dig_al"}, {6'b0, dig_sel_al},   8'h03);
        chk({tag, "_led_al"}, {6'b0, buzz_led_al, fizz_led_al}, 8'h00);
    endtask

    // One clock: record inputs, advance model, compare after the edge, return at negedge.
    task automatic step();
        logic [17:0] a2, a3;
        @(posedge clk);
        k++;
        hist[k] = {buzz, fizz, seg1, seg0};
        a2 = s2_at(k);
        a3 = s3_at(k);
        if (a2[16] && !a3[16]) f_off = (k / SD + ST) * SD;
        if (a2[17] && !a3[17]) b_off = (k / SD + ST) * SD;
        model_scan(k, e_seg, e_dig);
        #1;
        chk("seg",     seg_out,                e_seg);
        chk("dig",     {6'b0, dig_sel},        {6'b0, e_dig});
        chk("fizz",    {7'b0, fizz_led},       {7'b0, (k < f_off)});
        chk("buzz",    {7'b0, buzz_led},       {7'b0, (k < b_off)});
        chk("seg_al",  seg_out_al,             ~e_seg);
        chk("dig_al",  {6'b0, dig_sel_al},     {6'b0, ~e_dig});
        chk("fizz_al", {7'b0, fizz_led_al},    {7'b0, (k < f_off)});
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        f_off = 0;
        b_off = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        seg0  = 8'hB7;
        seg1  = 8'h14;
        fizz  = 1'b0;
        buzz  = 1'b0;

        // Scenario 1/5: reset values on both polarities, then scan timing.
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        release_reset();
        steps(30);
        $display("scan basic: edges=%0d bad=%0d", k, bad);

        // Scenario 2: change SEG0 mid-DIG0 (frame 2 DIG0 spans edges 28..35).
        seg0 = 8'h73;
        steps(30);
        $display("frozen pattern: edges=%0d bad=%0d", k, bad);

        // Scenario 3: single-cycle fizz pulse.
        fizz = 1'b1;
        step();
        fizz = 1'b0;
        steps(25);
        $display("fizz pulse: edges=%0d bad=%0d", k, bad);

        // Scenario 4: retrigger while lit, with a simultaneous buzz pulse.
        fizz = 1'b1;
        step();
        fizz = 1'b0;
        steps(6);
        fizz = 1'b1;
        buzz = 1'b1;
        step();
        fizz = 1'b0;
        buzz = 1'b0;
        steps(25);
        fizz = 1'b1;
        steps(40);
        fizz = 1'b0;
        steps(20);
        $display("retrigger and held level: edges=%0d bad=%0d", k, bad);

        // Random inputs against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) seg0 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) seg1 = 8'($urandom);
            fizz = ($urandom_range(0, 9) == 0);
            buzz = ($urandom_range(0, 9) == 0);
            step();
        end
        fizz = 1'b0;
        buzz = 1'b0;
        $display("random: edges=%0d bad=%0d", k, bad);

        // Scenario 6: asynchronous reset in the middle of DIG1 with LEDs lit.
        for (int i = 0; i < 30 && e_dig != 2'b10; i++) step();
        chk("dig1_reached", {6'b0, e_dig}, 8'h02);
        fizz = 1'b1;
        buzz = 1'b1;
        step();
        fizz = 1'b0;
        buzz = 1'b0;
        steps(2);
        chk("led_lit_pre_rst", {6'b0, buzz_led, fizz_led}, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        release_reset();
        seg0 = 8'h5A;
        steps(30);
        $display("async reset recovery: edges=%0d bad=%0d", k, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
